tt_vec_idp_wb: RTL

//  Writeback collector directly downstream of the integer datapath. Captures the adder-path result
//  (1a) and multiplier/narrowing-path result (2a), merges them in age order into a small FIFO and

---
 rtl/tt_vec_wb_pkg.sv | 20 ++
 rtl/tt_vec_wb_fifo.sv | 55 +++++
 rtl/tt_vec_idp_wb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/tt_vec_wb_pkg.sv
// Shared entry type, stall threshold and pointer helper for the vector integer writeback collector.
package tt_vec_wb_pkg;

  localparam int WB_VLEN         = 256;
  localparam int WB_BEW          = WB_VLEN / 8;
  localparam int WB_TAGW         = 5;
  localparam int WB_DEPTH        = 4;
  localparam int WB_STALL_THRESH = 4;

  typedef struct packed {
    logic [WB_VLEN-1:0] data;
    logic [WB_BEW-1:0]  be;
    logic [WB_TAGW-1:0] tag;
  } wb_entry_t;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr + 32'd1 == depth) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/tt_vec_wb_fifo.sv
// Two-write / one-read FIFO of writeback entries; write port 0 is always the older entry.
module tt_vec_wb_fifo
  import tt_vec_wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          wr0_en,
  input  wb_entry_t     wr0_entry,
  input  logic          wr1_en,
  input  wb_entry_t     wr1_entry,
  input  logic          rd_en,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_p1;
  logic [PW-1:0] wr_ptr_p2;
  logic [PW-1:0] rd_ptr_p1;
  logic [PW-1:0] wr1_addr;

  assign wr_ptr_p1 = PW'(ptr_inc(32'(wr_ptr), DEPTH));
  assign wr_ptr_p2 = PW'(ptr_inc(32'(wr_ptr_p1), DEPTH));
  assign rd_ptr_p1 = PW'(ptr_inc(32'(rd_ptr), DEPTH));

  // The younger entry lands directly behind the older one when both are written.
  assign wr1_addr  = wr0_en ? wr_ptr_p1 : wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (wr0_en) mem[wr_ptr] <= wr0_entry;
    if (wr1_en) mem[wr1_addr] <= wr1_entry;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr0_en && wr1_en)     wr_ptr <= wr_ptr_p2;
      else if (wr0_en || wr1_en) wr_ptr <= wr_ptr_p1;
      if (rd_en) rd_ptr <= rd_ptr_p1;
      count <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

endmodule

// File: rtl/tt_vec_idp_wb.sv
// Writeback collector behind the integer datapath: age-ordered merge of 1a/2a results into a FIFO
// draining to the VRF port. Optional same-cycle bypass when TT_VEC_WB_BYPASS_EN is defined.
module tt_vec_idp_wb
  import tt_vec_wb_pkg::*;
#(
  parameter int VLEN  = WB_VLEN,
  parameter int DEPTH = WB_DEPTH,
  parameter int TAGW  = WB_TAGW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_data_vld_1a,
  input  logic [VLEN-1:0]   i_data_1a,
  input  logic [VLEN/8-1:0] i_be_1a,
  input  logic [TAGW-1:0]   i_tag_1a,
  input  logic              i_data_vld_2a,
  input  logic [VLEN-1:0]   i_data_2a,
  input  logic [VLEN/8-1:0] i_be_2a,
  input  logic [TAGW-1:0]   i_tag_2a,
  input  logic              i_sat_csr_2a,
  input  logic              i_vxsat_clr,
  input  logic              i_wb_rdy,
  output logic              o_wb_vld,
  output logic [VLEN-1:0]   o_wb_data,
  output logic [VLEN/8-1:0] o_wb_be,
  output logic [TAGW-1:0]   o_wb_tag,
  output logic              o_stall_0a,
  output logic              o_vxsat,
  output logic              o_ovf_err
);

  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     in_1a;
  wb_entry_t     in_2a;
  wb_entry_t     in_old;
  wb_entry_t     in_new;
  wb_entry_t     head;
  wb_entry_t     fifo_wr0;
  wb_entry_t     wb_entry;
  logic          req_old;
  logic          req_new;
  logic          bypass_take;
  logic          cand0_vld;
  logic          cand1_vld;
  logic          wr0_en;
  logic          wr1_en;
  logic          drop;
  logic          fifo_vld;
  logic          pop;
  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic [CW-1:0] count_next;

  assign in_1a = '{data: i_data_1a, be: i_be_1a, tag: i_tag_1a};
  assign in_2a = '{data: i_data_2a, be: i_be_2a, tag: i_tag_2a};

  // The 2a result belongs to the older instruction, so it always goes first.
  assign req_old = i_data_vld_1a | i_data_vld_2a;
  assign req_new = i_data_vld_1a & i_data_vld_2a;
  assign in_old  = i_data_vld_2a ? in_2a : in_1a;
  assign in_new  = in_1a;

`ifdef TT_VEC_WB_BYPASS_EN
  assign bypass_take = (count == '0) & i_wb_rdy & req_old & ~i_reset;
`else
  assign bypass_take = 1'b0;
`endif

  // A bypassed oldest entry leaves only the younger one (if any) for the FIFO.
  always_comb begin
    fifo_wr0  = in_old;
    cand0_vld = req_old & ~i_reset;
    cand1_vld = req_new & ~i_reset;
    if (bypass_take) begin
      fifo_wr0  = in_new;
      cand0_vld = req_new & ~i_reset;
      cand1_vld = 1'b0;
    end
  end

  assign free   = CW'(DEPTH) - count;
  assign wr0_en = cand0_vld & (free != '0);
  assign wr1_en = cand1_vld & (free > CW'(1));
  assign drop   = (cand0_vld & ~wr0_en) | (cand1_vld & ~wr1_en);

  tt_vec_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .wr0_en    (wr0_en),
    .wr0_entry (fifo_wr0),
    .wr1_en    (wr1_en),
    .wr1_entry (in_new),
    .rd_en     (pop),
    .head      (head),
    .count     (count)
  );

  // VRF handshake: o_wb_vld never drops and o_wb_* never change until the cycle where
  // o_wb_vld & i_wb_rdy are both high; that cycle transfers exactly one entry.
  assign fifo_vld = (count != '0) & ~i_reset;
  assign pop      = fifo_vld & i_wb_rdy;
  assign o_wb_vld = fifo_vld | bypass_take;

  always_comb begin
    wb_entry = '0;
    if (fifo_vld)         wb_entry = head;
    else if (bypass_take) wb_entry = in_old;
  end

  assign o_wb_data = wb_entry.data;
  assign o_wb_be   = wb_entry.be;
  assign o_wb_tag  = wb_entry.tag;

  assign count_next = count + CW'(wr0_en) + CW'(wr1_en) - CW'(pop);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_stall_0a <= 1'b0;
      o_vxsat    <= 1'b0;
      o_ovf_err  <= 1'b0;
    end else begin
      o_stall_0a <= (CW'(DEPTH) - count_next) < CW'(WB_STALL_THRESH);
      if (i_data_vld_2a && i_sat_csr_2a) o_vxsat <= 1'b1;
      else if (i_vxsat_clr)              o_vxsat <= 1'b0;
      if (drop) o_ovf_err <= 1'b1;
    end
  end

endmodule
